radix8_pp_accumulator: RTL and testbench

Sequential consumer of the radix-8 Booth select signals. It takes one signed multiplicand, builds the hard multiple 3A once, then accepts one Booth digit per handshake, LSB group first. Each digit arrives as a negate flag plus one-hot selects {Ex4,Ex3,Ex2,Ex1}. The block selects the partial product ±{0,A,2A,3A,4A}, weights it by 8^i and accumulates a 2·WIDTH-bit two's-complement product. It sits downstream of the Booth select-signal encoders in the signed approximate-multiplier datapath and serves as the exact reference/low-area serial path.

---
 rtl/radix8_pkg.sv | 23 ++
 rtl/radix8_pp_select.sv | 44 ++++
 rtl/radix8_pp_accumulator.sv | 109 ++++++++++
 tb/tb_radix8_pp_accumulator.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/radix8_pkg.sv
// Shared types and helpers for the radix-8 Booth partial-product accumulator.
package radix8_pkg;

    // Controller states of the serial accumulator.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Bit positions inside the one-hot digit select {Ex4,Ex3,Ex2,Ex1}.
    localparam int unsigned EX1 = 0;
    localparam int unsigned EX2 = 1;
    localparam int unsigned EX3 = 2;
    localparam int unsigned EX4 = 3;

    // Number of radix-8 digits needed to cover a signed operand of this width.
    function automatic int unsigned ndig(input int unsigned width);
        return (width + 2) / 3;
    endfunction

endpackage

// File: rtl/radix8_pp_select.sv
// Combinational partial-product selector: picks +/-{0,A,2A,3A,4A} for one Booth digit.
module radix8_pp_select
    import radix8_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH+1:0] i_a3,
    input  logic [3:0]       i_sel,
    input  logic             i_neg,
    output logic [WIDTH+2:0] o_mult,
    output logic             o_malformed
);

    logic [WIDTH+2:0] w_a_ext;
    logic [WIDTH+2:0] w_mag;

    // WIDTH+3 bits holds 4A for the most negative A without overflow.
    assign w_a_ext     = {{3{i_a[WIDTH-1]}}, i_a};
    // More than one select bit set: clearing the lowest set bit leaves something.
    assign o_malformed = (i_sel & (i_sel - 4'd1)) != 4'd0;

    // Magnitude selection; malformed or empty selects contribute zero.
    always_comb begin
        w_mag = '0;
        if (!o_malformed) begin
            if (i_sel[EX1]) begin
                w_mag = w_a_ext;
            end else if (i_sel[EX2]) begin
                w_mag = w_a_ext << 1;
            end else if (i_sel[EX3]) begin
                w_mag = {i_a3[WIDTH+1], i_a3};
            end else if (i_sel[EX4]) begin
                w_mag = w_a_ext << 2;
            end
        end
    end

    // Two's-complement negation; a zero magnitude stays zero.
    always_comb begin
        o_mult = i_neg ? (~w_mag + (WIDTH+3)'(1)) : w_mag;
    end

endmodule

// File: rtl/radix8_pp_accumulator.sv
// Serial radix-8 Booth multiplier back end: one digit per handshake, LSB group first.
module radix8_pp_accumulator
    import radix8_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned NDIG  = ndig(WIDTH),
    localparam int unsigned PW    = 2 * WIDTH,
    localparam int unsigned CW    = $clog2(NDIG + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic             dig_valid,
    output logic             dig_ready,
    input  logic             dig_neg,
    input  logic [3:0]       dig_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    product,
    output logic             out_err
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH+1:0] r_a3;
    logic [PW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_err;

    logic [WIDTH+1:0] w_a3;
    logic [WIDTH+2:0] w_mult;
    logic             w_malformed;
    logic [PW-1:0]    w_mult_ext;
    logic [CW+1:0]    w_shamt;
    logic [PW-1:0]    w_addend;
    logic             w_dig_fire;
    logic             w_last_dig;

    radix8_pp_select #(
        .WIDTH (WIDTH)
    ) u_select (
        .i_a         (r_a),
        .i_a3        (r_a3),
        .i_sel       (dig_sel),
        .i_neg       (dig_neg),
        .o_mult      (w_mult),
        .o_malformed (w_malformed)
    );

    assign w_a3       = {{2{r_a[WIDTH-1]}}, r_a} + {r_a[WIDTH-1], r_a, 1'b0};
    assign w_mult_ext = {{(PW - WIDTH - 3){w_mult[WIDTH+2]}}, w_mult};
    // Digit weight 8^i is a shift by 3*i.
    assign w_shamt    = {1'b0, r_cnt, 1'b0} + {2'b00, r_cnt};
    // Bits shifted past the product width are dropped, giving modulo arithmetic.
    assign w_addend   = w_mult_ext << w_shamt;
    assign w_dig_fire = (r_state == ACC) && dig_valid;
    assign w_last_dig = (r_cnt == CW'(NDIG - 1));

    // Ready/valid are decoded from state only; start_ready is also held low during reset.
    assign start_ready = rst_n && (r_state == IDLE);
    assign dig_ready   = (r_state == ACC);
    assign out_valid   = (r_state == DONE);
    assign product     = r_acc;
    assign out_err     = r_err;

    // Next-state decode for the controller.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (start_valid)             w_state_nxt = PRE;
            PRE:                               w_state_nxt = ACC;
            ACC:  if (w_dig_fire && w_last_dig) w_state_nxt = DONE;
            DONE: if (out_ready)               w_state_nxt = IDLE;
            default:                           w_state_nxt = IDLE;
        endcase
    end

    // State, operand and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_a3    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && start_valid) begin
                r_a   <= a_in;
                r_acc <= '0;
                r_cnt <= '0;
                r_err <= 1'b0;
            end
            if (r_state == PRE) begin
                r_a3 <= w_a3;
            end
            if (w_dig_fire) begin
                r_acc <= r_acc + w_addend;
                r_cnt <= r_cnt + CW'(1);
                r_err <= r_err | w_malformed;
            end
        end
    end

endmodule

// File: tb/tb_radix8_pp_accumulator.sv
// Self-checking bench for radix8_pp_accumulator (WIDTH=8, three digits per product).
module tb_radix8_pp_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [7:0]  a_in;
    logic        dig_valid;
    logic        dig_ready;
    logic        dig_neg;
    logic [3:0]  dig_sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        out_err;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic       dn [3];
    logic [3:0] ds [3];

    radix8_pp_accumulator #(
        .WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .dig_valid   (dig_valid),
        .dig_ready   (dig_ready),
        .dig_neg     (dig_neg),
        .dig_sel     (dig_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product),
        .out_err     (out_err)
    );

    always #5 clk = ~clk;

    // Free-running cycle index used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: product = sum of A * d_i * 8^i over well-formed digits, mod 2^16.
    function automatic void model(input logic [7:0] a, output logic [15:0] p, output logic e);
        longint s;
        longint d;
        s = 0;
        e = 1'b0;
        for (int i = 0; i < 3; i++) begin
            case (ds[i])
                4'b0000: d = 0;
                4'b0001: d = 1;
                4'b0010: d = 2;
                4'b0100: d = 3;
                4'b1000: d = 4;
                default: begin d = 0; e = 1'b1; end
            endcase
            if (dn[i]) d = -d;
            s += longint'($signed(a)) * d * (longint'(1) << (3 * i));
        end
        p = s[15:0];
    endfunction

    task automatic set_digs(input logic n0, input logic [3:0] s0, input logic n1,
                            input logic [3:0] s1, input logic n2, input logic [3:0] s2);
        dn[0] = n0; ds[0] = s0;
        dn[1] = n1; ds[1] = s1;
        dn[2] = n2; ds[2] = s2;
    endtask

    // One full product: start, digits (optional 3-cycle stall before digit stall_at),
    // then hold out_ready low for 'hold' cycles before consuming.
    task automatic run_op(input string tag, input logic [7:0] a, input int stall_at,
                          input int hold);
        int         t;
        int         i;
        int         stalled;
        logic       seen;
        logic [15:0] ep;
        logic       ee;
        model(a, ep, ee);
        @(negedge clk);
        chk({tag, "_start_ready"}, start_ready, 1);
        start_valid = 1'b1;
        a_in        = a;
        t           = cyc;
        i           = 0;
        stalled     = 0;
        seen        = 1'b0;
        for (int g = 0; g < 40 && !seen; g++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
            end else begin
                // Stray start requests outside IDLE must be ignored.
                start_valid = 1'b1;
                a_in        = 8'($urandom);
                if (dig_ready && i < 3 && !(i == stall_at && stalled < 3)) begin
                    dig_valid = 1'b1;
                    dig_neg   = dn[i];
                    dig_sel   = ds[i];
                    i++;
                end else if (dig_ready && i < 3) begin
                    dig_valid = 1'b0;
                    dig_neg   = 1'b1;
                    dig_sel   = 4'hF;
                    stalled++;
                end else begin
                    // Malformed junk offered while not ready must not be taken.
                    dig_valid = 1'b1;
                    dig_neg   = 1'b1;
                    dig_sel   = 4'hF;
                end
            end
        end
        start_valid = 1'b0;
        dig_valid   = 1'b0;
        chk({tag, "_out_valid_seen"}, seen, 1);
        chk({tag, "_latency"}, cyc - t, (stall_at >= 0 && stall_at < 3) ? 8 : 5);
        chk({tag, "_product"}, product, ep);
        chk({tag, "_out_err"}, out_err, ee);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            @(negedge clk);
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_product"}, product, ep);
            chk({tag, "_hold_start_ready"}, start_ready, 0);
            chk({tag, "_hold_dig_ready"}, dig_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_post_out_valid"}, out_valid, 0);
        chk({tag, "_post_start_ready"}, start_ready, 1);
    endtask

    initial begin
        rst_n       = 1'b0;
        start_valid = 1'b0;
        a_in        = '0;
        dig_valid   = 1'b0;
        dig_neg     = 1'b0;
        dig_sel     = '0;
        out_ready   = 1'b0;

        // Values while reset is held.
        repeat (2) @(negedge clk);
        chk("rst_start_ready", start_ready, 0);
        chk("rst_dig_ready", dig_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_product", product, 0);
        chk("rst_out_err", out_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_start_ready", start_ready, 1);

        // Directed products.
        set_digs(0, 4'b0100, 0, 4'b0000, 0, 4'b0000);
        run_op("a5", 8'd5, -1, 0);
        set_digs(0, 4'b0000, 0, 4'b0000, 1, 4'b0010);
        run_op("am128", 8'h80, -1, 0);
        set_digs(1, 4'b0001, 0, 4'b0000, 0, 4'b0010);
        run_op("a127", 8'd127, -1, 0);
        set_digs(1, 4'b1000, 0, 4'b1000, 0, 4'b0000);
        run_op("am3", 8'hFD, -1, 0);
        set_digs(0, 4'b0011, 0, 4'b0000, 0, 4'b0000);
        run_op("malformed", 8'd5, -1, 0);
        set_digs(0, 4'b0100, 1, 4'b0000, 0, 4'b0000);
        run_op("clean_after_err", 8'd5, -1, 0);

        // Stall mid-ACC, then back-pressure on the result.
        set_digs(1, 4'b0001, 0, 4'b0000, 0, 4'b0010);
        run_op("stall", 8'd127, 1, 0);
        set_digs(1, 4'b1000, 0, 4'b1000, 0, 4'b0000);
        run_op("hold", 8'hFD, -1, 4);

        // Reset pulsed after the second digit.
        @(negedge clk);
        start_valid = 1'b1;
        a_in        = 8'd37;
        @(negedge clk);
        start_valid = 1'b0;
        @(negedge clk);
        dig_valid = 1'b1; dig_neg = 1'b0; dig_sel = 4'b0011;
        @(negedge clk);
        dig_valid = 1'b1; dig_neg = 1'b0; dig_sel = 4'b1000;
        @(negedge clk);
        dig_valid = 1'b0; dig_sel = 4'b0000;
        chk("mid_product_nonzero", (product != 16'd0), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_start_ready", start_ready, 0);
        chk("mid_rst_dig_ready", dig_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_product", product, 0);
        chk("mid_rst_out_err", out_err, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_start_ready", start_ready, 1);
        repeat (6) begin
            @(negedge clk);
            chk("mid_rel_no_out_valid", out_valid, 0);
        end

        // Randomised products against the arithmetic model.
        for (int k = 0; k < 24; k++) begin
            for (int j = 0; j < 3; j++) begin
                int r;
                r     = int'($urandom_range(0, 9));
                dn[j] = 1'($urandom);
                case (r)
                    0: ds[j] = 4'b0000;
                    1, 2: ds[j] = 4'b0001;
                    3, 4: ds[j] = 4'b0010;
                    5, 6: ds[j] = 4'b0100;
                    7, 8: ds[j] = 4'b1000;
                    default: ds[j] = (4'b0011 << $urandom_range(0, 2)) | 4'($urandom);
                endcase
            end
            run_op("rand", 8'($urandom), int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
